// File: rtl/rf_pulse_tx.sv
// Pulse-position RF frame transmitter: 8-bit preamble then payload, MSB first, one pulse per '1' slot.
// Define RF_PULSE_TX_PARITY_EN to append an even-parity slot after the payload.
module rf_pulse_tx #(
  parameter int         PACKET_SIZE  = 24,
  parameter logic [7:0] PREAMBLE     = 8'hFF,
  parameter int         BIT_PERIOD   = 10000,
  parameter int         PULSE_OFFSET = 5000,
  parameter int         PULSE_WIDTH  = 1
) (
  input  logic                   i_PCLK,
  input  logic                   i_PRESETn,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [PACKET_SIZE-1:0] i_data,
  input  logic                   i_abort,
  output logic                   o_rfout,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [5:0]             o_bit_idx
);

`ifdef RF_PULSE_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int SLOTS   = 8 + PACKET_SIZE + PAR_BITS;
  localparam int SHIFT_W = SLOTS;
  localparam int CNT_W   = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W:0]   P_LO     = (CNT_W+1)'(PULSE_OFFSET);
  localparam logic [CNT_W:0]   P_HI     = (CNT_W+1)'(PULSE_OFFSET + PULSE_WIDTH);

  if ((PULSE_OFFSET + PULSE_WIDTH > BIT_PERIOD) || (PULSE_WIDTH == 0) ||
      (BIT_PERIOD < 2) || (SLOTS > 64)) begin : g_bad_params
    $error("rf_pulse_tx: illegal pulse timing or frame length parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_PAY,
`ifdef RF_PULSE_TX_PARITY_EN
    S_PAR,
`endif
    S_DONE
  } state_t;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [5:0]         r_bit_idx, w_bit_idx_next;
  logic [SHIFT_W-1:0] r_shift, w_shift_next;
  logic               r_rfout;
  logic               w_rfout_next;
  logic               w_slot_end;
  logic [SHIFT_W-1:0] w_load;
  logic [CNT_W:0]     w_cnt_ext;

  function automatic logic is_busy(input state_t s);
    return (s == S_PRE) || (s == S_PAY)
`ifdef RF_PULSE_TX_PARITY_EN
           || (s == S_PAR)
`endif
           ;
  endfunction

`ifdef RF_PULSE_TX_PARITY_EN
  assign w_load = {PREAMBLE, i_data, ^i_data};
`else
  assign w_load = {PREAMBLE, i_data};
`endif

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_rfout   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_rfout   <= w_rfout_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_slot_end     = (r_cnt == CNT_LAST);
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_state_next   = S_PRE;
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_shift_next   = w_load;
        end
      end
      S_PRE,
`ifdef RF_PULSE_TX_PARITY_EN
      S_PAR,
`endif
      S_PAY: begin
        if (i_abort) begin
          w_state_next   = S_IDLE;
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_shift_next   = '0;
        end else if (w_slot_end) begin
          w_cnt_next     = '0;
          w_bit_idx_next = r_bit_idx + 6'd1;
          w_shift_next   = r_shift << 1;
          if (r_bit_idx == 6'(SLOTS - 1)) begin
            // Counters are parked at zero for the DONE cycle.
            w_state_next   = S_DONE;
            w_bit_idx_next = '0;
            w_shift_next   = '0;
`ifdef RF_PULSE_TX_PARITY_EN
          end else if (r_bit_idx == 6'(8 + PACKET_SIZE - 1)) begin
            w_state_next = S_PAR;
`endif
          end else if (r_bit_idx == 6'd7) begin
            w_state_next = S_PAY;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // The pulse is decided from next-cycle state so o_rfout comes straight from a flop.
  assign w_cnt_ext    = {1'b0, w_cnt_next};
  assign w_rfout_next = is_busy(w_state_next) && (w_cnt_ext >= P_LO) &&
                        (w_cnt_ext < P_HI) && w_shift_next[SHIFT_W-1];

  assign o_rfout   = r_rfout;
  assign o_ready   = (r_state == S_IDLE);
  assign o_busy    = is_busy(r_state);
  assign o_done    = (r_state == S_DONE);
  assign o_bit_idx = r_bit_idx;

endmodule

// File: tb/tb_rf_pulse_tx.sv
// Directed bench for rf_pulse_tx: expected pulse and done cycles are queued at accept and popped by a monitor.
// Parity slot expectations follow RF_PULSE_TX_PARITY_EN when it is defined.
module tb_rf_pulse_tx;
  localparam int PS = 24;
  localparam int BP = 16;
  localparam int PO = 8;
  localparam int PW = 2;
`ifdef RF_PULSE_TX_PARITY_EN
  localparam int NS = 8 + PS + 1;
`else
  localparam int NS = 8 + PS;
`endif
  localparam int FRAME_LEN = NS * BP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          abort = 1'b0;
  logic [PS-1:0] data = '0;
  logic          ready, rfout, busy, done;
  logic [5:0]    bit_idx;

  rf_pulse_tx #(
    .PACKET_SIZE(PS), .PREAMBLE(8'hFF), .BIT_PERIOD(BP),
    .PULSE_OFFSET(PO), .PULSE_WIDTH(PW)
  ) dut (
    .i_PCLK(clk), .i_PRESETn(rst_n), .i_valid(valid), .o_ready(ready),
    .i_data(data), .i_abort(abort), .o_rfout(rfout), .o_busy(busy),
    .o_done(done), .o_bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int q_rise[$];
  int q_done[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Queue the pulse rise cycles of the first nslots slots of a frame whose slot 0 starts at cycle k.
  task automatic push_frame(input int k, input logic [PS-1:0] d, input int nslots, input bit with_done);
    logic [NS-1:0] bits;
`ifdef RF_PULSE_TX_PARITY_EN
    bits = {8'hFF, d, ^d};
`else
    bits = {8'hFF, d};
`endif
    for (int s = 0; s < nslots; s++)
      if (bits[NS-1-s]) q_rise.push_back(k + s*BP + PO);
    if (with_done) q_done.push_back(k + NS*BP);
  endtask

  task automatic queues_empty(input string tag);
    chk({tag, "_pulses_left"}, 32'(q_rise.size()), 32'd0);
    chk({tag, "_done_left"}, 32'(q_done.size()), 32'd0);
  endtask

  // Called just after a negedge while idle; runs one full frame.
  task automatic run_frame(input logic [PS-1:0] d, input bit with_abort);
    int k;
    chk("ready_before_accept", 32'(ready), 32'd1);
    valid = 1'b1;
    abort = with_abort;
    data  = d;
    k = cyc + 1;
    push_frame(k, d, NS, 1'b1);
    @(negedge clk);
    valid = 1'b0;
    abort = 1'b0;
    data  = ~d;
    repeat (8*BP) @(negedge clk);
    chk("bit_idx_slot8", 32'(bit_idx), 32'd8);
    chk("busy_in_frame", 32'(busy), 32'd1);
    chk("ready_in_frame", 32'(ready), 32'd0);
    repeat (FRAME_LEN - 8*BP + 4) @(negedge clk);
    queues_empty("frame");
  endtask

  logic prev_rf = 1'b0;
  int   run = 0;
  int   busy_run = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rf  = 1'b0;
      run      = 0;
      busy_run = 0;
    end else begin
      if (rfout === 1'b1 && !prev_rf) begin
        chk("pulse_expected", 32'(q_rise.size() != 0), 32'd1);
        if (q_rise.size() != 0) chk("pulse_cycle", 32'(cyc), 32'(q_rise.pop_front()));
      end
      if (rfout !== 1'b1 && prev_rf) chk("pulse_width", 32'(run), 32'(PW));
      run     = (rfout === 1'b1) ? run + 1 : 0;
      prev_rf = (rfout === 1'b1);
      if (done === 1'b1) begin
        chk("done_expected", 32'(q_done.size() != 0), 32'd1);
        if (q_done.size() != 0) chk("done_cycle", 32'(cyc), 32'(q_done.pop_front()));
        chk("busy_len", 32'(busy_run), 32'(FRAME_LEN));
      end
      busy_run = (busy === 1'b1) ? busy_run + 1 : 0;
    end
  end

  initial begin
    int k1, k2, k;

    repeat (3) @(negedge clk);
    chk("reset_rfout", 32'(rfout), 32'd0);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_bit_idx", 32'(bit_idx), 32'd0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_rfout", 32'(rfout), 32'd0);
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    run_frame(24'hA50000, 1'b0);
    run_frame(24'h000000, 1'b0);
    run_frame(24'hFFFFFF, 1'b0);

    // Back-to-back with i_valid held high: second frame starts 2 cycles after done.
    valid = 1'b1;
    data  = 24'h123456;
    k1 = cyc + 1;
    k2 = k1 + FRAME_LEN + 2;
    push_frame(k1, 24'h123456, NS, 1'b1);
    push_frame(k2, 24'h89ABCD, NS, 1'b1);
    @(negedge clk);
    data = 24'h89ABCD;
    repeat (FRAME_LEN + 10) @(negedge clk);
    valid = 1'b0;
    chk("b2b_second_busy", 32'(busy), 32'd1);
    chk("b2b_bit_idx", 32'(bit_idx), 32'd0);
    repeat (FRAME_LEN) @(negedge clk);
    queues_empty("b2b");

    // Abort at slot 20, cycle 9 while the pulse is high.
    valid = 1'b1;
    data  = 24'hFFFFFF;
    k = cyc + 1;
    push_frame(k, 24'hFFFFFF, 21, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    repeat (20*BP + 9) @(negedge clk);
    chk("abort_pre_rfout", 32'(rfout), 32'd1);
    chk("abort_pre_bit_idx", 32'(bit_idx), 32'd20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_rfout", 32'(rfout), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    queues_empty("abort");

    // Immediate re-accept, with i_abort asserted in the accept cycle (accept wins).
    run_frame(24'h000000, 1'b1);

`ifdef RF_PULSE_TX_PARITY_EN
    run_frame(24'h000007, 1'b0);
    run_frame(24'h000003, 1'b0);
`endif

    // Reset mid-pulse drops o_rfout at once and never pulses o_done.
    valid = 1'b1;
    data  = 24'hFFFFFF;
    k = cyc + 1;
    push_frame(k, 24'hFFFFFF, 1, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    repeat (PO) @(negedge clk);
    chk("midreset_pre_rfout", 32'(rfout), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rfout", 32'(rfout), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_ready", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_rfout", 32'(rfout), 32'd0);
    queues_empty("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_pulse_tx.md
Name: rf_pulse_tx

Overview:
- Transmits one packet as a pulse-position RF frame on a single line.
- Frame is an 8-bit preamble followed by a PACKET_SIZE-bit payload, MSB first.
- Each bit occupies a fixed slot of BIT_PERIOD clocks. A '1' produces one pulse at a fixed offset inside its slot; a '0' produces no pulse.
- Sits in front of the rfin receive path. It is the on-chip stimulus source for, and the transmit counterpart of, the APB-controlled SPI/RF receiver.

Parameters:
- PACKET_SIZE, 24, payload bits per frame.
- PREAMBLE, 8'hFF, preamble byte, sent MSB first before the payload.
- BIT_PERIOD, 10000, clocks per bit slot (1 ms at a 10 MHz clock).
- PULSE_OFFSET, 5000, clocks from slot start to the pulse rising edge (50% position).
- PULSE_WIDTH, 1, pulse high time in clocks.
- Elaboration error if PULSE_OFFSET+PULSE_WIDTH > BIT_PERIOD, PULSE_WIDTH = 0, or BIT_PERIOD < 2.

Ports:
- i_PCLK  in  1  clock, rising edge.
- i_PRESETn  in  1  asynchronous active-low reset.
- i_valid  in  1  packet request.
- o_ready  out  1  block idle; accepts i_data when i_valid is also high.
- i_data  in  PACKET_SIZE  payload, sampled on accept.
- i_abort  in  1  synchronous abort of the current frame.
- o_rfout  out  1  pulse output, registered.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse at normal frame completion.
- o_bit_idx  out  6  index of the current slot: 0..7 preamble, 8.. payload.

Behaviour:
- Reset (asynchronous, immediate): o_rfout=0, o_busy=0, o_done=0, o_ready=1, o_bit_idx=0, FSM=IDLE, all counters 0, shift register 0.
- States: IDLE, PRE, PAY, (PAR, see option), DONE.
- IDLE:
  - o_ready=1.
  - Accept = i_valid & o_ready on a rising edge.
  - On accept: latch {PREAMBLE, i_data} into the shift register, slot_cnt=0, bit_idx=0, go to PRE.
- Slot timing:
  - The cycle after accept is slot 0, cycle 0.
  - slot_cnt counts 0..BIT_PERIOD-1, then wraps to 0 and advances bit_idx and the shift register (shift left).
  - o_rfout=1 exactly during slot cycles PULSE_OFFSET .. PULSE_OFFSET+PULSE_WIDTH-1 when the current MSB is 1. It is registered, with no combinational path from inputs.
- PRE: 8 slots, then PAY at bit_idx=8.
- PAY: PACKET_SIZE slots, then DONE (or PAR).
- DONE:
  - Lasts one cycle.
  - o_done=1, o_busy=0, o_ready=0.
  - Returns to IDLE. o_ready rises on the next cycle.
- Frame length: (8+PACKET_SIZE)*BIT_PERIOD cycles of o_busy=1.
- o_busy=1 in PRE, PAY and PAR. o_ready=1 only in IDLE.
- i_valid while not ready: ignored, no queuing. i_data is don't-care outside accept.
- i_abort:
  - In PRE, PAY or PAR: next cycle FSM=IDLE, o_rfout=0 (a pulse is truncated), o_busy=0, no o_done.
  - In IDLE: ignored.
  - i_abort and i_valid in the same IDLE cycle: accept wins.
- Back-to-back frames: minimum gap is 2 cycles (DONE cycle plus IDLE accept cycle). No pulse is ever split across a slot boundary.
- Reset asserted mid-frame: o_rfout drops asynchronously. The frame is lost and o_done is not pulsed.

Optional Feature:
- RF_PULSE_TX_PARITY_EN defined:
  - After the payload, one extra PAR slot (bit_idx=8+PACKET_SIZE) carries even parity of i_data (XOR of all payload bits).
  - The slot uses the same pulse encoding.
  - Frame is (9+PACKET_SIZE)*BIT_PERIOD cycles.
- Undefined: no PAR state; frame ends after the payload.

Test Plan:
- All scenarios use BIT_PERIOD=16, PULSE_OFFSET=8, PULSE_WIDTH=2.
- Reset then idle 50 cycles -> o_rfout=0, o_ready=1, o_busy=0, o_done never asserted.
- Accept i_data=24'hA50000 -> 8 preamble pulses, then payload pulses in slots 8,10,13,15 only. Each pulse is high at slot cycles 8–9. o_busy is high for exactly 512 cycles, then one o_done pulse.
- i_data=24'h000000 -> pulses only in slots 0–7. i_data=24'hFFFFFF -> 32 pulses, spaced 16 cycles apart.
- i_valid held high continuously with payloads 24'h123456 then 24'h89ABCD -> second frame starts 2 cycles after o_done. The second frame's first pulse lands 8 cycles into its slot 0. No overlap between frames.
- i_abort at slot 20, cycle 9 (mid-pulse) -> next cycle o_rfout=0, o_busy=0, o_ready=1, no o_done. A new accept is then immediately possible.
- With RF_PULSE_TX_PARITY_EN, i_data=24'h000007 -> pulse in slot 32 (odd count of ones gives parity 1) and frame length 528 cycles. i_data=24'h000003 -> no pulse in slot 32.
